// File: rtl/ram_sweep.sv
// Single-port word RAM that clears itself after reset or on request.
// Optional macro RAM_SWEEP_BYPASS_EN: read+write in one cycle returns the write data.
module ram_sweep #(
   parameter int unsigned          DATA_W    = 8,
   parameter int unsigned          ADDR_W    = 8,
   parameter logic [DATA_W-1:0]    CLEAR_VAL = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              read,
   input  logic              write,
   input  logic              clear,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] out,
   output logic              out_valid,
   output logic              busy
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      ST_SWEEP = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   state_t              r_state;
   logic [ADDR_W-1:0]   r_sweep_ptr;
   logic                r_busy;
   logic [DATA_W-1:0]   r_out;
   logic                r_out_valid;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic                w_idle_access;
   logic                w_rd_en;
   logic                w_wr_en;
   logic                w_sweep_done;
   logic                w_mem_we;
   logic [ADDR_W-1:0]   w_mem_addr;
   logic [DATA_W-1:0]   w_mem_din;
   logic [DATA_W-1:0]   w_rd_data;

   // Accesses are honoured only in IDLE and only when no clear is requested.
   assign w_idle_access = (r_state == ST_IDLE) && !clear;
   assign w_rd_en       = w_idle_access && read;
   assign w_wr_en       = w_idle_access && write;
   assign w_sweep_done  = (r_sweep_ptr == {ADDR_W{1'b1}});

   // The sweep owns the write port; user writes use it only in IDLE.
   assign w_mem_we   = (r_state == ST_SWEEP) || w_wr_en;
   assign w_mem_addr = (r_state == ST_SWEEP) ? r_sweep_ptr : address;
   assign w_mem_din  = (r_state == ST_SWEEP) ? CLEAR_VAL   : data;

   // Read and write share one address, so a combined access is always same-address.
`ifdef RAM_SWEEP_BYPASS_EN
   assign w_rd_data = w_wr_en ? data : r_mem[address];
`else
   assign w_rd_data = r_mem[address];
`endif

   // Storage carries no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_din;
      end
   end

   // Sweep/idle control with registered busy and read data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_SWEEP;
         r_sweep_ptr <= '0;
         r_busy      <= 1'b1;
         r_out       <= '0;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= 1'b0;
         case (r_state)
            ST_SWEEP: begin
               r_sweep_ptr <= r_sweep_ptr + ADDR_W'(1);
               if (w_sweep_done) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            end
            ST_IDLE: begin
               if (clear) begin
                  r_state     <= ST_SWEEP;
                  r_sweep_ptr <= '0;
                  r_busy      <= 1'b1;
               end else if (w_rd_en) begin
                  r_out       <= w_rd_data;
                  r_out_valid <= 1'b1;
               end
            end
            default: begin
               r_state     <= ST_SWEEP;
               r_sweep_ptr <= '0;
               r_busy      <= 1'b1;
            end
         endcase
      end
   end

   assign out       = r_out;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;

endmodule

// File: tb/tb_ram_sweep.sv
// Scoreboard bench for ram_sweep: a memory-array model predicts each cycle,
// a monitor compares busy/out_valid/out against the queued predictions.
module tb_ram_sweep;

   localparam int unsigned DW    = 8;
   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 16;
   localparam logic [DW-1:0] CLR = 8'hFF;

   logic          clk;
   logic          rst_n;
   logic          read;
   logic          write;
   logic          clear;
   logic [AW-1:0] address;
   logic [DW-1:0] data;
   logic [DW-1:0] out;
   logic          out_valid;
   logic          busy;

   ram_sweep #(
      .DATA_W    (DW),
      .ADDR_W    (AW),
      .CLEAR_VAL (CLR)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .read      (read),
      .write     (write),
      .clear     (clear),
      .address   (address),
      .data      (data),
      .out       (out),
      .out_valid (out_valid),
      .busy      (busy)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   typedef struct packed {
      logic          busy;
      logic          valid;
      logic [DW-1:0] out;
   } exp_t;

   exp_t          ctl_q[$];
   logic [DW-1:0] data_q[$];
   int            n_checks = 0;
   int            n_fail   = 0;

   // Reference model: whole-array clear at sweep start, remaining-cycle counter for busy.
   logic [DW-1:0] m_mem [DEPTH];
   int            m_left = 0;
   logic [DW-1:0] m_out  = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fill_clear();
      for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = CLR;
   endtask

   task automatic cyc(input logic rst, input logic rd, input logic wr, input logic clr,
                      input logic [AW-1:0] a, input logic [DW-1:0] d);
      exp_t e;
      logic v;
      @(negedge clk);
      rst_n   = rst;
      read    = rd;
      write   = wr;
      clear   = clr;
      address = a;
      data    = d;
      v = 1'b0;
      if (!rst) begin
         m_left = DEPTH;
         m_out  = '0;
         fill_clear();
      end else if (m_left > 0) begin
         m_left--;
      end else if (clr) begin
         m_left = DEPTH;
         fill_clear();
      end else begin
         if (rd) begin
            m_out = m_mem[a];
`ifdef RAM_SWEEP_BYPASS_EN
            if (wr) m_out = d;
`endif
            v = 1'b1;
            data_q.push_back(m_out);
         end
         if (wr) m_mem[a] = d;
      end
      e.busy  = (m_left > 0);
      e.valid = v;
      e.out   = m_out;
      ctl_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
   endtask

   task automatic rnd(input int n, input int clr_odds);
      for (int i = 0; i < n; i++)
         cyc(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             (clr_odds > 0) ? ($urandom_range(0, clr_odds - 1) == 0) : 1'b0,
             AW'($urandom), DW'($urandom));
   endtask

   // Monitor: one prediction per rising edge, read data popped when out_valid is seen.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (ctl_q.size() > 0) begin
            e = ctl_q.pop_front();
            check("busy", 64'(busy), 64'(e.busy));
            check("out_valid", 64'(out_valid), 64'(e.valid));
            if (out_valid) begin
               if (data_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL out_unexpected: got %0h with no read outstanding at %0t", out, $time);
               end else begin
                  check("out", 64'(out), 64'(data_q.pop_front()));
               end
            end else begin
               check("out_hold", 64'(out), 64'(e.out));
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; read = 1'b0; write = 1'b0; clear = 1'b0; address = '0; data = '0;

      // Reset then the automatic sweep, then read every address.
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      idle(18);
      for (int i = 0; i < int'(DEPTH); i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, AW'(i), '0);
      idle(2);

      // Write then read, and hold afterwards.
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 8'hA5);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'h3, '0);
      idle(3);

      // Combined read and write to one address.
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'h7, 8'h11);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'h7, 8'h22);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'h7, '0);
      idle(2);

      // Random traffic with occasional clears.
      rnd(400, 64);
      idle(18);

      // Clear with a concurrent write, traffic ignored while busy.
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 4'h2, 8'h55);
      rnd(16, 0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'h2, '0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0, 4'hF, '0);
      idle(2);

      // Populate, then reset in the middle of a sweep.
      rnd(30, 0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1, '0, '0);
      rnd(5, 0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 4'h4, 8'h3C);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
      rnd(16, 0);
      for (int i = 0; i < int'(DEPTH); i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, AW'(i), '0);
      rnd(100, 0);
      idle(2);

      @(posedge clk);
      #2;
      check("ctl_q_drained", 64'(ctl_q.size()), 64'(0));
      check("data_q_drained", 64'(data_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
